// File: rtl/output_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | output_serializer: captures a DATA_W word and streams it as BEATS        |
// | valid/ready beats, LS word first. Define OUTPUT_SER_PARITY_EN for out_par.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module output_serializer #(
  parameter int DATA_W = 256,
  parameter int WORD_W = 32,
  parameter int BEATS  = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clear_ovr,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              overrun
`ifdef OUTPUT_SER_PARITY_EN
  ,
  output logic              out_par
`endif
);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              ovr_q, ovr_d;
  logic              xfer, final_xfer, accept;
  logic [WORD_W-1:0] words [BEATS];

  for (genvar g = 0; g < BEATS; g++) begin : g_words
    assign words[g] = hold_q[g*WORD_W +: WORD_W];
  end

  always_comb begin
    xfer       = (state_q == SEND) && out_ready;
    final_xfer = xfer && (idx_q == LAST_IDX);
    // A load is taken only when the holding register is free at this edge.
    accept     = load && ((state_q == IDLE) || final_xfer);
    state_d    = state_q;
    hold_d     = hold_q;
    idx_d      = idx_q;
    ovr_d      = ovr_q;
    if (accept) begin
      hold_d  = data_in;
      idx_d   = '0;
      state_d = SEND;
    end else if (final_xfer) begin
      idx_d   = '0;
      state_d = IDLE;
    end else if (xfer) begin
      idx_d   = idx_q + IDX_W'(1);
    end
    if (load && !accept) begin
      ovr_d = 1'b1;
    end else if (clear_ovr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      ovr_q   <= ovr_d;
    end
  end

  assign busy      = (state_q == SEND);
  assign out_valid = (state_q == SEND);
  assign out_idx   = idx_q;
  assign out_data  = out_valid ? words[idx_q] : '0;
  assign out_last  = out_valid && (idx_q == LAST_IDX);
  assign overrun   = ovr_q;

`ifdef OUTPUT_SER_PARITY_EN
  assign out_par   = ^out_data;
`endif

endmodule
`default_nettype wire

// File: doc/output_serializer.md
# output_serializer

Downstream neighbour of `output_reg`. It captures the 256-bit word the output register drives on its `data` bus and streams it out as eight 32-bit beats over a valid/ready handshake, least-significant word first. It decouples the wide internal result from a narrow external consumer such as a debug port or host link, and flags any load it cannot accept.

## Interface
Parameters:
- `DATA_W`, 256: width of captured word; must equal `BEATS*WORD_W`.
- `WORD_W`, 32: width of one output beat.
- `BEATS`, 8: beats per word.
- `IDX_W`, 3: width of beat index; equals clog2(`BEATS`).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset; clears all state immediately.
- `load`  in  1  single-cycle strobe: capture `data_in` this cycle.
- `data_in`  in  DATA_W  word from `output_reg`'s `data` output.
- `clear_ovr`  in  1  synchronous clear of `overrun`.
- `busy`  out  1  high while a word is held or being streamed.
- `out_valid`  out  1  beat on `out_data` is valid.
- `out_ready`  in  1  consumer accepts the beat.
- `out_data`  out  WORD_W  current beat.
- `out_idx`  out  IDX_W  index of the current beat, 0..BEATS-1.
- `out_last`  out  1  high when `out_idx == BEATS-1` and `out_valid` is high.
- `overrun`  out  1  sticky: a load was dropped.
- `out_par`  out  1  even parity of `out_data`. Present only under `OUTPUT_SER_PARITY_EN`.

## Operation
- States:
  - IDLE: `busy`=0, `out_valid`=0.
  - SEND: `busy`=1, `out_valid`=1.
- IDLE + `load`:
  - Capture `data_in` into the holding register and set `out_idx`=0.
  - Move to SEND.
- SEND:
  - `out_data` = holding register bits [`out_idx`*WORD_W +: WORD_W].
  - A transfer occurs on a rising edge where `out_valid && out_ready`.
  - On a transfer with `out_idx` < BEATS-1, increment `out_idx`.
  - On a transfer with `out_idx` == BEATS-1, return to IDLE and reset `out_idx` to 0.
- Back-to-back loads: if `load` is high on the same edge as the final-beat transfer, capture the new word, set `out_idx`=0, and stay in SEND. `out_valid` does not drop.
- Dropped loads:
  - `load` in SEND, other than on the final-beat transfer edge, is ignored and the held word is unaffected.
  - A dropped load sets `overrun`=1.
- `overrun` clears only on `reset` or `clear_ovr`. If `clear_ovr` and a dropped `load` fall on the same edge, the set wins.
- Stability: while `out_valid && !out_ready`, `out_data`, `out_idx`, `out_last` and `out_valid` hold constant.
- `data_in` is sampled only on accepted loads; changes at other times have no effect.

## Timing
- Reset values: `busy`=0, `out_valid`=0, `out_data`=0, `out_idx`=0, `out_last`=0, `overrun`=0, `out_par`=0, holding register 0, state IDLE.
- Reset asserted mid-stream aborts the word at once; nothing is emitted after reset releases until a new `load`.
- Load latency: `load` sampled at edge N; beat 0 is valid from just after edge N (cycle N+1).
- Throughput: with `out_ready` held high, one beat per cycle. Eight beats occupy cycles N+1..N+8.
- Return to IDLE: `out_valid` falls after the final-beat edge unless a back-to-back load occurred.
- `out_data`, `out_last`, `out_idx` and `out_par` are decoded combinationally from registered state; there are no combinational paths from inputs to outputs.
- `out_ready` may be high while `out_valid` is low; no transfer occurs.

## Configuration
- `OUTPUT_SER_PARITY_EN` defined:
  - `out_par` port exists and equals XOR-reduction of `out_data`, so `out_data` plus `out_par` has an even number of ones.
  - `out_par` is 0 in reset and IDLE.
- Undefined: no `out_par` port and no parity logic; all other behaviour is identical.

## Test plan
- Reset then idle: assert `reset` mid-cycle; all outputs 0 asynchronously. Release; `out_valid` stays 0 with `out_ready`=1 for 10 cycles.
- Full stream with `out_ready`=1:
  - Load `data_in` = 256'h5555…5555 → eight beats of 32'h55555555, `out_idx` 0..7, `out_last` only on beat 7, then `busy`=0.
  - Parity check: with `OUTPUT_SER_PARITY_EN`, `out_par`=0 on every beat.
- Ordering and backpressure:
  - Load 256'hAA walked by 32 bytes (word k = 32'h000000AA << 8*(k%4)).
  - Toggle `out_ready` 1,0,0,1,…
  - Beats arrive in index order, and `out_data` holds steady during stalls.
- Back-to-back: load 256'hAAAA…AAAA, then load 256'h5555…5555 on the beat-7 transfer edge → 16 consecutive beats, `out_valid` never low, `overrun`=0.
- Overrun: load any word, hold `out_ready`=0, pulse `load` again → `overrun`=1 and the original beats still emerge unchanged. Pulse `clear_ovr` → `overrun`=0.
- Reset mid-stream: reset after beat 3 transfers → `out_valid`=0 immediately. A later load of 256'h1 streams beat 0 = 32'h1, then seven beats of 0.
